// File: rtl/req_arbiter_8.sv
// req_arbiter_8: 8-way round-robin arbiter with registered one-hot grant and a rotating search pointer.
// Define ARB_TIMEOUT_EN to revoke a grant after MAX_HOLD cycles and pulse timeout.
module req_arbiter_8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic       gnt_valid,
  output logic [2:0] gnt_id,
  output logic       timeout
);
  localparam int NUM_LANES = 8;
  localparam int PW        = 3;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

  state_e               state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [PW-1:0]        gnt_id_q, gnt_id_d;
  logic [NUM_LANES-1:0] gnt_q, gnt_d;
  logic                 gnt_valid_q, gnt_valid_d;
  logic [NUM_LANES-1:0] win;
  logic [PW-1:0]        win_id;
  logic                 own_req;
  logic                 limit;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_q, hold_d;
  logic       timeout_q, timeout_d;

  // Compare one cycle ahead so the grant lasts exactly MAX_HOLD cycles.
  assign limit = ({1'b0, hold_q} + 9'd1) == 9'(MAX_HOLD);
`else
  logic unused_max_hold;

  assign limit           = 1'b0;
  assign unused_max_hold = ^8'(MAX_HOLD);
`endif

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    req_arbiter_8_lane #(
      .NUM_LANES (NUM_LANES),
      .PW        (PW),
      .IDX       (i)
    ) u_lane (
      .req (req),
      .ptr (ptr_q),
      .win (win[i])
    );
  end

  // win is one-hot or zero, so OR-ing indices yields the binary id.
  always_comb begin
    win_id = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (win[i]) win_id = win_id | PW'(i);
    end
  end

  assign own_req = req[gnt_id_q];

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
`ifdef ARB_TIMEOUT_EN
    hold_d      = hold_q;
    timeout_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d     = GRANT;
          gnt_d       = win;
          gnt_id_d    = win_id;
          gnt_valid_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
          hold_d      = '0;
`endif
        end
      end
      GRANT: begin
        if (!own_req || limit) begin
          state_d     = IDLE;
          ptr_d       = gnt_id_q + PW'(1);
          gnt_d       = '0;
          gnt_id_d    = '0;
          gnt_valid_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
          // A release on the limit edge counts as a normal release.
          timeout_d   = own_req;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
          hold_d      = hold_q + 8'd1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_q      <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
`ifdef ARB_TIMEOUT_EN
      hold_q      <= hold_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;
`ifdef ARB_TIMEOUT_EN
  assign timeout   = timeout_q;
`else
  assign timeout   = 1'b0;
`endif

endmodule

// Per-lane winner: lane IDX wins when it requests and no requester sits
// closer to ptr in the circular search order.
module req_arbiter_8_lane #(
  parameter int NUM_LANES = 8,
  parameter int PW        = 3,
  parameter int IDX       = 0
) (
  input  logic [NUM_LANES-1:0] req,
  input  logic [PW-1:0]        ptr,
  output logic                 win
);
  logic [PW-1:0] my_dist;
  logic [PW-1:0] dist_j;
  logic          blocked;

  always_comb begin
    my_dist = PW'(IDX) - ptr;
    dist_j  = '0;
    blocked = 1'b0;
    for (int j = 0; j < NUM_LANES; j++) begin
      dist_j = PW'(j) - ptr;
      if (req[j] && (dist_j < my_dist)) blocked = 1'b1;
    end
    win = req[IDX] && !blocked;
  end

endmodule
